mux_scan_ctrl: RTL

Sequential scan controller for the 16:1 mux tree. It drives the 4-bit select of `mux_16x1`, waits a programmable settle time per channel and samples the mux's 1-bit output. It assembles the 16 samples into a parallel word and presents it with a one-cycle `done` pulse. It sits in a closed loop around `mux_16x1`: its `sel` output feeds the mux's `s` input, and the mux's `y` output returns on `mux_y`.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/settle_timer.sv | 31 +++
 rtl/mux_scan_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan controller.
package mux_scan_pkg;
  localparam int NCH   = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: counts while enabled and raises tc at SETTLE-1.
// It wraps to zero on its own terminal count, so back-to-back channels
// need no extra clear cycle.
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

  logic [3:0] cnt_q, cnt_d;

  assign tc = (cnt_q == TC_VAL);

  // Next count: clear dominates, then count with wrap on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? 4'd0 : cnt_q + 4'd1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 16:1 mux: steps the select, waits SETTLE cycles
// per channel, samples the mux output and publishes a whole 16-bit word
// with a one-cycle done pulse.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_y,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [NCH-1:0]   data
);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   data_q, data_d;
  logic             done_q, done_d;
  logic             tc;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_SETTLE),
    .clr (state_q != ST_SETTLE),
    .tc  (tc)
  );

  // Next-state logic; data is loaded from the shadow with the final
  // channel merged in so it never shows a partial word.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          sel_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (tc) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        shadow_d[sel_q] = mux_y;
        if (sel_q == SEL_LAST) begin
          state_d = ST_DONE;
          data_d  = shadow_d;
          done_d  = 1'b1;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        sel_d   = '0;
        state_d = cont ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, select, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign data = data_q;
endmodule
